demux_scan_seq: RTL and testbench

DEMUX_SCAN_SEQ -- requirements
Module: demux_scan_seq

---
 rtl/demux_scan_seq.sv | 168 ++++++++++++++++
 tb/tb_demux_scan_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scan_seq.sv
// Channel scan sequencer driving a 1:32 demux: it walks sel from first_ch to last_ch,
// holding each channel for a dwell period and an optional idle gap.
module demux_scan_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [4:0]       first_ch,
  input  logic [4:0]       last_ch,
  input  logic [CNT_W-1:0] dwell,
  input  logic [CNT_W-1:0] gap,
  input  logic             data_in,
  output logic [4:0]       sel,
  output logic             dout,
  output logic             ch_valid,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [4:0]       r_sel;
  logic [4:0]       r_first;
  logic [4:0]       r_last;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cont;
  logic             r_ch_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic             w_dwell_end;
  logic             w_gap_end;
  state_t           w_nxt_state;
  logic [4:0]       w_nxt_sel;
  logic             w_nxt_wrap;

  // A dwell of zero is treated as a single cycle.
  assign w_dwell_end = (r_dwell == CNT_ZERO) || (r_cnt == (r_dwell - CNT_ONE));
  assign w_gap_end   = (r_cnt == (r_gap - CNT_ONE));

  // Where the scan goes once the current channel (dwell plus any gap) is finished.
  always_comb begin
    w_nxt_state = S_DRIVE;
    w_nxt_sel   = r_sel + 5'd1;
    w_nxt_wrap  = 1'b0;
    if (r_sel == r_last) begin
      if (r_cont) begin
        w_nxt_sel  = r_first;
        w_nxt_wrap = 1'b1;
      end else begin
        w_nxt_state = S_DONE;
        w_nxt_sel   = r_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= 5'd0;
      r_first    <= 5'd0;
      r_last     <= 5'd0;
      r_dwell    <= CNT_ZERO;
      r_gap      <= CNT_ZERO;
      r_cnt      <= CNT_ZERO;
      r_cont     <= 1'b0;
      r_ch_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_first    <= first_ch;
            r_last     <= last_ch;
            r_dwell    <= dwell;
            r_gap      <= gap;
            r_cont     <= cont;
            r_sel      <= first_ch;
            r_cnt      <= CNT_ZERO;
            r_state    <= S_DRIVE;
            r_ch_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_DRIVE: begin
          if (stop) begin
            r_state    <= S_IDLE;
            r_cnt      <= CNT_ZERO;
            r_ch_valid <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_dwell_end) begin
            r_cnt <= CNT_ZERO;
            if (r_gap != CNT_ZERO) begin
              r_state    <= S_GAP;
              r_ch_valid <= 1'b0;
            end else begin
              r_state    <= w_nxt_state;
              r_sel      <= w_nxt_sel;
              r_wrap     <= w_nxt_wrap;
              r_ch_valid <= (w_nxt_state == S_DRIVE);
              r_done     <= (w_nxt_state == S_DONE);
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_GAP: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
          end else if (w_gap_end) begin
            r_cnt      <= CNT_ZERO;
            r_state    <= w_nxt_state;
            r_sel      <= w_nxt_sel;
            r_wrap     <= w_nxt_wrap;
            r_ch_valid <= (w_nxt_state == S_DRIVE);
            r_done     <= (w_nxt_state == S_DONE);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state    <= S_IDLE;
          r_ch_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign sel      = r_sel;
  assign dout     = data_in & r_ch_valid;
  assign ch_valid = r_ch_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_demux_scan_seq.sv
// Bench for demux_scan_seq: directed and randomized scans compared cycle by cycle
// against a trace model built from the scan rules.
module tb_demux_scan_seq;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             cont;
  logic [4:0]       first_ch;
  logic [4:0]       last_ch;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] gap;
  logic             data_in;
  logic [4:0]       sel;
  logic             dout;
  logic             ch_valid;
  logic             busy;
  logic             done;
  logic             wrap;

  demux_scan_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .first_ch(first_ch), .last_ch(last_ch), .dwell(dwell), .gap(gap),
    .data_in(data_in), .sel(sel), .dout(dout), .ch_valid(ch_valid),
    .busy(busy), .done(done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sel;
    bit cv;
    bit busy;
    bit done;
    bit wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input int idx, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, expv);
    end
  endtask

  // Expected per-cycle trace after the start edge, derived from the scan rules.
  task automatic build(input int f, input int l, input int d, input int g,
                       input bit c, input int maxlen);
    int ch;
    bit wflag;
    exp_t e;
    exp_q.delete();
    ch = f;
    wflag = 0;
    while (exp_q.size() < maxlen) begin
      for (int i = 0; i < ((d == 0) ? 1 : d); i++) begin
        e = '{sel: ch, cv: 1, busy: 1, done: 0, wrap: (i == 0) && wflag};
        exp_q.push_back(e);
      end
      wflag = 0;
      for (int i = 0; i < g; i++) begin
        e = '{sel: ch, cv: 0, busy: 1, done: 0, wrap: 0};
        exp_q.push_back(e);
      end
      if (ch == l) begin
        if (c) begin
          ch = f;
          wflag = 1;
        end else begin
          e = '{sel: ch, cv: 0, busy: 1, done: 1, wrap: 0};
          exp_q.push_back(e);
          e = '{sel: ch, cv: 0, busy: 0, done: 0, wrap: 0};
          exp_q.push_back(e);
          break;
        end
      end else begin
        ch = (ch + 1) % 32;
      end
    end
    while (exp_q.size() > maxlen) void'(exp_q.pop_back());
  endtask

  task automatic chk_entry(input string tag, input int idx, input exp_t e);
    chk({tag, ".sel"}, idx, int'(sel), e.sel);
    chk({tag, ".ch_valid"}, idx, int'(ch_valid), int'(e.cv));
    chk({tag, ".busy"}, idx, int'(busy), int'(e.busy));
    chk({tag, ".done"}, idx, int'(done), int'(e.done));
    chk({tag, ".wrap"}, idx, int'(wrap), int'(e.wrap));
    chk({tag, ".dout"}, idx, int'(dout), e.cv ? int'(data_in) : 0);
  endtask

  task automatic idle_cycles(input string tag, input int n, input int exp_sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = 1'b1;
      #1;
      chk({tag, ".busy"}, i, int'(busy), 0);
      chk({tag, ".sel"}, i, int'(sel), exp_sel);
      chk({tag, ".dout"}, i, int'(dout), 0);
      chk({tag, ".done"}, i, int'(done), 0);
    end
  endtask

  // Start a scan and follow the model; abort_idx >= 0 raises stop during that entry.
  task automatic run_scan(input string tag, input int f, input int l, input int d,
                          input int g, input bit c, input int maxlen,
                          input int abort_idx, input bit noise);
    int n;
    build(f, l, d, g, c, maxlen);
    n = (abort_idx >= 0) ? abort_idx + 1 : exp_q.size();
    @(negedge clk);
    first_ch = 5'(f); last_ch = 5'(l); dwell = CNT_W'(d); gap = CNT_W'(g); cont = c;
    start = 1'b1; stop = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_ch = 5'($urandom); last_ch = 5'($urandom);
    dwell = CNT_W'($urandom); gap = CNT_W'($urandom); cont = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = 1'($urandom);
      #1;
      chk_entry(tag, i, exp_q[i]);
      start = (noise && exp_q[i].busy && (i != exp_q.size() - 1)) ? 1'($urandom) : 1'b0;
      if (i == abort_idx) begin
        stop  = 1'b1;
        start = 1'b0;
      end
    end
    if (abort_idx >= 0) begin
      @(posedge clk);
      #1;
      stop = 1'b0;
      idle_cycles({tag, ".abort"}, 3, exp_q[abort_idx].sel);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
    first_ch = '0; last_ch = '0; dwell = '0; gap = '0; data_in = 1'b1;
    #23;
    chk("rst.sel", 0, int'(sel), 0);
    chk("rst.dout", 0, int'(dout), 0);
    chk("rst.ch_valid", 0, int'(ch_valid), 0);
    chk("rst.busy", 0, int'(busy), 0);
    chk("rst.done", 0, int'(done), 0);
    chk("rst.wrap", 0, int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("idle", 2, 0);

    run_scan("single", 3, 5, 2, 1, 1'b0, 1000, -1, 1'b0);
    run_scan("wrapwin", 30, 1, 1, 0, 1'b0, 1000, -1, 1'b0);
    run_scan("contin", 0, 1, 1, 0, 1'b1, 12, 11, 1'b0);
    run_scan("abort", 3, 6, 1, 3, 1'b0, 1000, 6, 1'b0);
    run_scan("dwell0", 7, 9, 0, 2, 1'b0, 1000, -1, 1'b0);
    run_scan("onech", 12, 12, 3, 1, 1'b0, 1000, -1, 1'b1);

    // start and stop together in IDLE
    @(negedge clk);
    first_ch = 5'd2; last_ch = 5'd4; dwell = 8'd1; gap = 8'd0; cont = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    idle_cycles("startstop", 3, 12);

    // asynchronous reset between edges in the middle of a DRIVE period
    build(20, 22, 5, 0, 1'b0, 1000);
    @(negedge clk);
    first_ch = 5'd20; last_ch = 5'd22; dwell = 8'd5; gap = 8'd0; cont = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      data_in = 1'b1;
      #1;
      chk_entry("prerst", i, exp_q[i]);
    end
    @(negedge clk);
    data_in = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.sel", 0, int'(sel), 0);
    chk("arst.dout", 0, int'(dout), 0);
    chk("arst.ch_valid", 0, int'(ch_valid), 0);
    chk("arst.busy", 0, int'(busy), 0);
    chk("arst.done", 0, int'(done), 0);
    chk("arst.wrap", 0, int'(wrap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles("postrst", 3, 0);
    run_scan("clean", 20, 22, 2, 1, 1'b0, 1000, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      run_scan("rand", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0,
               1000, -1, 1'b1);
    end
    for (int t = 0; t < 3; t++) begin
      run_scan("randcont", int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1,
               40, 39, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
